// File: rtl/md_pkg.sv
// Shared HI/LO op codes and issue-controller state encoding, used by the
// pipeline decoder, md_issue_ctrl and mul_div.
package md_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] MD_MULT  = 4'h0;
    localparam logic [OP_W-1:0] MD_MULTU = 4'h1;
    localparam logic [OP_W-1:0] MD_DIV   = 4'h2;
    localparam logic [OP_W-1:0] MD_DIVU  = 4'h3;
    localparam logic [OP_W-1:0] MD_MTHI  = 4'h4;
    localparam logic [OP_W-1:0] MD_MTLO  = 4'h5;
    localparam logic [OP_W-1:0] MD_MFHI  = 4'h6;
    localparam logic [OP_W-1:0] MD_MFLO  = 4'h7;
    localparam logic [OP_W-1:0] MD_NONE  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUED = 2'd1,
        ST_WAIT   = 2'd2
    } md_state_t;

endpackage

// File: rtl/md_issue_ctrl.sv
// E-stage initiator for the multiply/divide unit: issues Start/op/A/B, tracks the
// in-flight op, raises the D-stage stall and returns HI/LO for mfhi/mflo.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int ACK_TIMEOUT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            e_valid,
    input  logic [OP_W-1:0] e_md_op,
    input  logic [31:0]     e_rs,
    input  logic [31:0]     e_rt,
    input  logic            flush,
    input  logic            d_md_use,
    input  logic            md_busy,
    input  logic [31:0]     md_hi,
    input  logic [31:0]     md_lo,
    output logic            md_start,
    output logic [OP_W-1:0] md_op,
    output logic [31:0]     md_a,
    output logic [31:0]     md_b,
    output logic            stall_d,
    output logic [31:0]     e_md_rdata,
    output logic            md_err,
    output logic [1:0]      dbg_state
);

    localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    md_state_t        r_state;
    logic [ACK_W-1:0] r_ack_cnt;
    logic             r_err;

    logic w_kill;
    logic w_is_md;
    logic w_is_mt;
    logic w_idle;
    logic w_unit_free;
    logic w_start;
    logic w_mt_go;

    assign w_kill      = flush | ~e_valid;
    assign w_is_md     = (e_md_op <= MD_DIVU);
    assign w_is_mt     = (e_md_op == MD_MTHI) | (e_md_op == MD_MTLO);
    assign w_idle      = (r_state == ST_IDLE);
    // Gated by reset so the unit sees no Start and a neutral op during the reset cycle.
    assign w_unit_free = ~reset & ~w_kill & w_idle & ~md_busy;
    assign w_start     = w_is_md & w_unit_free;
    assign w_mt_go     = w_is_mt & w_unit_free;

    assign md_start   = w_start;
    // The unit writes Hi/Lo on mthi/mtlo whenever it is idle, so any other cycle must see MD_NONE.
    assign md_op      = (w_start | w_mt_go) ? e_md_op : MD_NONE;
    assign md_a       = e_rs;
    assign md_b       = e_rt;
    assign e_md_rdata = (e_md_op == MD_MFHI) ? md_hi :
                        (e_md_op == MD_MFLO) ? md_lo : 32'h0;
    // md_start and md_busy terms cover the Start->Busy gap before the FSM leaves IDLE.
    assign stall_d    = d_md_use & (~w_idle | w_start | md_busy);
    assign md_err     = r_err;
    assign dbg_state  = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ack_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state   <= ST_ISSUED;
                        r_ack_cnt <= '0;
                    end
                end
                ST_ISSUED: begin
                    if (md_busy) begin
                        r_state <= ST_WAIT;
                    end else if (r_ack_cnt == ACK_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!md_busy) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a small behavioural mul_div model.
module tb_md_issue_ctrl;
    import md_pkg::*;

    logic            clk;
    logic            reset;
    logic            e_valid;
    logic [OP_W-1:0] e_md_op;
    logic [31:0]     e_rs;
    logic [31:0]     e_rt;
    logic            flush;
    logic            d_md_use;
    logic            md_busy;
    logic [31:0]     md_hi;
    logic [31:0]     md_lo;
    logic            md_start;
    logic [OP_W-1:0] md_op;
    logic [31:0]     md_a;
    logic [31:0]     md_b;
    logic            stall_d;
    logic [31:0]     e_md_rdata;
    logic            md_err;
    logic [1:0]      dbg_state;

    int checks;
    int errors;
    int mthi_seen;

    md_issue_ctrl #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .e_valid(e_valid), .e_md_op(e_md_op),
        .e_rs(e_rs), .e_rt(e_rt), .flush(flush), .d_md_use(d_md_use),
        .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo),
        .md_start(md_start), .md_op(md_op), .md_a(md_a), .md_b(md_b),
        .stall_d(stall_d), .e_md_rdata(e_md_rdata), .md_err(md_err),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mul_div model: Busy rises two edges after Start, stays high two cycles.
    logic            no_ack;
    logic            pend;
    logic [OP_W-1:0] p_op;
    logic [31:0]     p_a;
    logic [31:0]     p_b;
    int              busy_left;
    logic [63:0]     prod;

    always @(posedge clk) begin
        if (reset) begin
            md_busy   <= 1'b0;
            md_hi     <= 32'h0;
            md_lo     <= 32'h0;
            pend      <= 1'b0;
            busy_left <= 0;
        end else begin
            if (md_start && !no_ack) begin
                pend <= 1'b1;
                p_op <= md_op;
                p_a  <= md_a;
                p_b  <= md_b;
            end else if (!md_busy && md_op == MD_MTHI) begin
                md_hi <= md_a;
            end else if (!md_busy && md_op == MD_MTLO) begin
                md_lo <= md_a;
            end
            if (pend) begin
                pend      <= 1'b0;
                md_busy   <= 1'b1;
                busy_left <= 2;
            end else if (md_busy) begin
                busy_left <= busy_left - 1;
                if (busy_left == 1) begin
                    md_busy <= 1'b0;
                    case (p_op)
                        MD_MULT: begin
                            prod = $signed(p_a) * $signed(p_b);
                            md_hi <= prod[63:32];
                            md_lo <= prod[31:0];
                        end
                        MD_MULTU: begin
                            prod = {32'h0, p_a} * {32'h0, p_b};
                            md_hi <= prod[63:32];
                            md_lo <= prod[31:0];
                        end
                        MD_DIV: if (p_b != 0) begin
                            md_lo <= $signed(p_a) / $signed(p_b);
                            md_hi <= $signed(p_a) % $signed(p_b);
                        end
                        default: if (p_b != 0) begin
                            md_lo <= p_a / p_b;
                            md_hi <= p_a % p_b;
                        end
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && md_op == MD_MTHI) mthi_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // driver tasks: step to just after an edge, then apply a cycle's inputs
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [OP_W-1:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic fl, input logic duse);
        e_valid  = v;
        e_md_op  = op;
        e_rs     = rs;
        e_rt     = rt;
        flush    = fl;
        d_md_use = duse;
        #2;
    endtask

    task automatic wait_state(input string tag, input logic [1:0] tgt, input int max_cyc);
        int n;
        n = 0;
        while (dbg_state != tgt && n < max_cyc) begin
            step();
            #2;
            n++;
        end
        chk(tag, {30'h0, dbg_state}, {30'h0, tgt});
    endtask

    initial begin
        checks = 0; errors = 0; mthi_seen = 0; no_ack = 1'b0;
        reset = 1'b1;
        drive(1'b1, MD_MULT, 32'h5, 32'h6, 1'b0, 1'b1);
        step(); #2;
        chk("rst_start", {31'h0, md_start}, 32'h0);
        chk("rst_op", {28'h0, md_op}, {28'h0, MD_NONE});
        chk("rst_state", {30'h0, dbg_state}, 32'h0);
        chk("rst_err", {31'h0, md_err}, 32'h0);
        step();
        reset = 1'b0;

        // mult FFFFFFFE*3 with mflo in D
        drive(1'b1, MD_MULT, 32'hFFFFFFFE, 32'h3, 1'b0, 1'b1);
        chk("mult_start", {31'h0, md_start}, 32'h1);
        chk("mult_op", {28'h0, md_op}, {28'h0, MD_MULT});
        chk("mult_a", md_a, 32'hFFFFFFFE);
        chk("mult_b", md_b, 32'h3);
        chk("mult_stall0", {31'h0, stall_d}, 32'h1);
        step(); drive(1'b0, MD_NONE, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("mult_start1", {31'h0, md_start}, 32'h0);
        chk("mult_st1", {30'h0, dbg_state}, 32'h1);
        chk("mult_stall1", {31'h0, stall_d}, 32'h1);
        step(); #2;
        chk("mult_busy2", {31'h0, md_busy}, 32'h1);
        chk("mult_stall2", {31'h0, stall_d}, 32'h1);
        step(); #2;
        chk("mult_st3", {30'h0, dbg_state}, 32'h2);
        chk("mult_stall3", {31'h0, stall_d}, 32'h1);
        step(); #2;
        chk("mult_busy4", {31'h0, md_busy}, 32'h0);
        chk("mult_stall4", {31'h0, stall_d}, 32'h1);
        step(); #2;
        chk("mult_stall5", {31'h0, stall_d}, 32'h0);
        chk("mult_st5", {30'h0, dbg_state}, 32'h0);
        drive(1'b1, MD_MFLO, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("mflo", e_md_rdata, 32'hFFFFFFFA);
        chk("mflo_op", {28'h0, md_op}, {28'h0, MD_NONE});
        step(); drive(1'b1, MD_MFHI, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("mfhi", e_md_rdata, 32'hFFFFFFFF);

        // divu 7/2 followed by ALU ops: no stall
        step(); drive(1'b1, MD_DIVU, 32'h7, 32'h2, 1'b0, 1'b0);
        chk("divu_start", {31'h0, md_start}, 32'h1);
        chk("divu_stall", {31'h0, stall_d}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step(); drive(1'b1, MD_NONE, 32'h0, 32'h0, 1'b0, 1'b0);
            chk("divu_alu_stall", {31'h0, stall_d}, 32'h0);
        end
        chk("divu_idle", {30'h0, dbg_state}, 32'h0);
        step(); drive(1'b1, MD_MFHI, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("divu_hi", e_md_rdata, 32'h1);
        step(); drive(1'b1, MD_MFLO, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("divu_lo", e_md_rdata, 32'h3);

        // mthi with idle unit, then mfhi next cycle
        step(); drive(1'b1, MD_MTHI, 32'h12345678, 32'h0, 1'b0, 1'b0);
        chk("mthi_op", {28'h0, md_op}, {28'h0, MD_MTHI});
        chk("mthi_start", {31'h0, md_start}, 32'h0);
        step(); drive(1'b1, MD_MFHI, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("mthi_rd", e_md_rdata, 32'h12345678);
        chk("mthi_st", {30'h0, dbg_state}, 32'h0);

        // flush in the same cycle as div
        step(); drive(1'b1, MD_DIV, 32'h9, 32'h2, 1'b1, 1'b0);
        chk("flush_start", {31'h0, md_start}, 32'h0);
        chk("flush_op", {28'h0, md_op}, {28'h0, MD_NONE});
        step(); drive(1'b0, MD_NONE, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("flush_st", {30'h0, dbg_state}, 32'h0);

        // flush while in WAIT: div -7/2 still completes
        step(); drive(1'b1, MD_DIV, 32'hFFFFFFF9, 32'h2, 1'b0, 1'b0);
        chk("fw_start", {31'h0, md_start}, 32'h1);
        step(); drive(1'b0, MD_NONE, 32'h0, 32'h0, 1'b0, 1'b0);
        wait_state("fw_wait", 2'd2, 8);
        drive(1'b1, MD_MULT, 32'h3, 32'h3, 1'b1, 1'b0);
        chk("fw_start_kill", {31'h0, md_start}, 32'h0);
        step(); drive(1'b0, MD_NONE, 32'h0, 32'h0, 1'b0, 1'b0);
        wait_state("fw_idle", 2'd0, 8);
        step(); drive(1'b1, MD_MFLO, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("fw_lo", e_md_rdata, 32'hFFFFFFFD);
        step(); drive(1'b1, MD_MFHI, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("fw_hi", e_md_rdata, 32'hFFFFFFFF);

        // unit never acknowledges: error after 4 cycles in ISSUED
        no_ack = 1'b1;
        step(); drive(1'b1, MD_MULTU, 32'h2, 32'h2, 1'b0, 1'b0);
        chk("to_start", {31'h0, md_start}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(); drive(1'b0, MD_NONE, 32'h0, 32'h0, 1'b0, 1'b0);
            chk("to_issued", {30'h0, dbg_state}, 32'h1);
            chk("to_err_low", {31'h0, md_err}, 32'h0);
        end
        step(); #2;
        chk("to_idle", {30'h0, dbg_state}, 32'h0);
        chk("to_err", {31'h0, md_err}, 32'h1);
        no_ack = 1'b0;

        // reset asserted in WAIT clears FSM and sticky error
        step(); drive(1'b1, MD_MULT, 32'h4, 32'h5, 1'b0, 1'b0);
        chk("rw_start", {31'h0, md_start}, 32'h1);
        step(); drive(1'b0, MD_NONE, 32'h0, 32'h0, 1'b0, 1'b0);
        wait_state("rw_wait", 2'd2, 8);
        chk("rw_err_sticky", {31'h0, md_err}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, MD_NONE, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("rw_st", {30'h0, dbg_state}, 32'h0);
        chk("rw_busy", {31'h0, md_busy}, 32'h0);
        chk("rw_stall", {31'h0, stall_d}, 32'h0);
        chk("rw_err", {31'h0, md_err}, 32'h0);

        step(); #2;
        chk("mthi_cycles", mthi_seen, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
